multi_channel_command_controller: RTL and testbench

MULTI_CHANNEL_COMMAND_CONTROLLER -- requirements
Module: multi_channel_command_controller

---
 rtl/multi_channel_command_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multi_channel_command_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_command_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_channel_command_controller
// Description : Routes core load/store/atomic commands into per-channel
//               command FIFOs, collects per-channel responses and arbitrates
//               register writebacks round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_command_controller #(
    parameter int DATABITWIDTH   = 16,
    parameter int PORTBYTEWIDTH  = 4,
    parameter int CHANNELCOUNT   = 4,
    parameter int FIFODEPTH      = 4,
    parameter int MAXOUTSTANDING = 3,
    localparam int PW            = PORTBYTEWIDTH * 8,
    localparam int CHBITS        = $clog2(CHANNELCOUNT)
) (
    input  logic                         sys_clk,
    input  logic                         sync_rst,
    input  logic                         clk_en,
    input  logic                         CommandACK,
    output logic                         CommandREQ,
    input  logic [3:0]                   MinorOpcodeIn,
    input  logic [CHBITS-1:0]            ChannelSelIn,
    input  logic [DATABITWIDTH-1:0]      CommandAddressIn_Offest,
    input  logic [DATABITWIDTH-1:0]      CommandDataIn,
    input  logic [3:0]                   CommandDestReg,
    output logic                         WritebackACK,
    input  logic                         WritebackREQ,
    output logic [3:0]                   WritebackDestReg,
    output logic [DATABITWIDTH-1:0]      WritebackDataOut,
    output logic [CHANNELCOUNT-1:0]      IOCmdACK,
    input  logic [CHANNELCOUNT-1:0]      IOCmdREQ,
    output logic [CHANNELCOUNT-1:0]      IOResponseRequested,
    output logic [CHANNELCOUNT*4-1:0]    IODestRegOut,
    output logic [CHANNELCOUNT*PW-1:0]   IODataOut,
    input  logic [CHANNELCOUNT-1:0]      IORespACK,
    output logic [CHANNELCOUNT-1:0]      IORespREQ,
    input  logic [CHANNELCOUNT-1:0]      IORegResponseFlag,
    input  logic [CHANNELCOUNT-1:0]      IOMemResponseFlag,
    input  logic [CHANNELCOUNT*4-1:0]    IODestRegIn,
    input  logic [CHANNELCOUNT*PW-1:0]   IODataIn
);

    localparam int SLICES = (PW + DATABITWIDTH - 1) / DATABITWIDTH;
    localparam int SLBITS = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int EXTW   = SLICES * DATABITWIDTH;
    localparam int ENTW   = PW + 5;
    localparam int PTRW   = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CNTW   = $clog2(FIFODEPTH + 1);
    localparam int OUTW   = $clog2(MAXOUTSTANDING + 1);

    localparam logic [1:0]        c_OP_LOAD   = 2'b00;
    localparam logic [1:0]        c_OP_STORE  = 2'b01;
    localparam logic [1:0]        c_OP_ATOMIC = 2'b10;
    localparam logic [1:0]        c_OP_STATUS = 2'b11;
    localparam logic [SLBITS-1:0] c_LASTSLICE = SLBITS'(SLICES - 1);
    localparam logic [OUTW-1:0]   c_MAXOUT    = OUTW'(MAXOUTSTANDING);

    // Per-channel state
    logic [ENTW-1:0]         r_fifoMem [CHANNELCOUNT][FIFODEPTH];
    logic [PTRW-1:0]         r_wrPtr   [CHANNELCOUNT];
    logic [PTRW-1:0]         r_rdPtr   [CHANNELCOUNT];
    logic [CNTW-1:0]         r_count   [CHANNELCOUNT];
    logic [EXTW-1:0]         r_stageReg[CHANNELCOUNT];
    logic [PW-1:0]           r_loadBuf [CHANNELCOUNT];
    logic [PW-1:0]           r_respData[CHANNELCOUNT];
    logic [3:0]              r_respDest[CHANNELCOUNT];
    logic [OUTW-1:0]         r_outstanding[CHANNELCOUNT];
    logic [CHANNELCOUNT-1:0] r_respValid;
    logic [CHBITS-1:0]       r_rrPtr;

    logic [CHANNELCOUNT-1:0] w_full, w_empty, w_push, w_pop;
    logic [CHANNELCOUNT-1:0] w_respAccept, w_respFree, w_outInc;
    logic [SLBITS-1:0]       w_slice;
    logic                    w_isLoad, w_isStore, w_isAtomic, w_isStatus, w_storePush;
    logic                    w_cmdFire, w_pushEn, w_wbFire, w_respFire;
    logic                    w_grantValid;
    logic [CHBITS-1:0]       w_grantCh;
    logic [EXTW-1:0]         w_stageMerged, w_loadExt, w_respWide;
    logic [DATABITWIDTH-1:0] w_loadSlice, w_status;
    logic [ENTW-1:0]         w_pushEntry;
    logic                    w_unused;

    assign w_isLoad    = (MinorOpcodeIn[3:2] == c_OP_LOAD);
    assign w_isStore   = (MinorOpcodeIn[3:2] == c_OP_STORE);
    assign w_isAtomic  = (MinorOpcodeIn[3:2] == c_OP_ATOMIC);
    assign w_isStatus  = (MinorOpcodeIn[3:2] == c_OP_STATUS);
    assign w_slice     = (SLICES > 1) ? CommandAddressIn_Offest[SLBITS-1:0] : '0;
    assign w_storePush = w_isStore && (w_slice == c_LASTSLICE);

    assign w_loadExt   = EXTW'(r_loadBuf[ChannelSelIn]);
    assign w_loadSlice = w_loadExt[w_slice*DATABITWIDTH +: DATABITWIDTH];
    assign w_status    = DATABITWIDTH'({r_outstanding[ChannelSelIn], r_count[ChannelSelIn],
                                        w_full[ChannelSelIn], w_empty[ChannelSelIn]});
    assign w_respWide  = EXTW'(r_respData[w_grantCh]);
    assign w_unused    = ^{MinorOpcodeIn[1:0], CommandAddressIn_Offest[DATABITWIDTH-1:SLBITS], w_respWide};

    // Stage register image with the incoming store slice merged in
    always_comb begin
        w_stageMerged = r_stageReg[ChannelSelIn];
        w_stageMerged[w_slice*DATABITWIDTH +: DATABITWIDTH] = CommandDataIn;
    end

    // FIFO entry being pushed: atomics carry the stage register as-is
    always_comb begin
        if (w_isAtomic) w_pushEntry = {1'b1, CommandDestReg, r_stageReg[ChannelSelIn][PW-1:0]};
        else            w_pushEntry = {1'b0, CommandDestReg, w_stageMerged[PW-1:0]};
    end

    // Round-robin pick among pending reg responses, starting at r_rrPtr
    always_comb begin
        w_grantValid = 1'b0;
        w_grantCh    = r_rrPtr;
        for (int i = CHANNELCOUNT - 1; i >= 0; i--) begin
            if (r_respValid[r_rrPtr + CHBITS'(i)]) begin
                w_grantValid = 1'b1;
                w_grantCh    = r_rrPtr + CHBITS'(i);
            end
        end
    end

    // Command ready: push-type ops stall on a full FIFO even if it pops this cycle
    always_comb begin
        CommandREQ = 1'b0;
        if (w_isLoad || w_isStatus) CommandREQ = WritebackREQ && !w_grantValid;
        else if (w_isStore)         CommandREQ = w_storePush ? !w_full[ChannelSelIn] : 1'b1;
        else                        CommandREQ = !w_full[ChannelSelIn] &&
                                                 (r_outstanding[ChannelSelIn] < c_MAXOUT);
    end

    assign w_cmdFire  = CommandACK && CommandREQ && clk_en;
    assign w_pushEn   = w_cmdFire && (w_storePush || w_isAtomic);
    assign w_wbFire   = WritebackACK && WritebackREQ && clk_en;
    assign w_respFire = w_wbFire && w_grantValid;

    // Writeback mux: pending reg responses win over same-cycle loads
    always_comb begin
        WritebackACK     = 1'b0;
        WritebackDestReg = '0;
        WritebackDataOut = '0;
        if (w_grantValid) begin
            WritebackACK     = 1'b1;
            WritebackDestReg = r_respDest[w_grantCh];
            WritebackDataOut = w_respWide[DATABITWIDTH-1:0];
        end else if (w_isLoad || w_isStatus) begin
            WritebackACK     = CommandACK;
            WritebackDestReg = CommandDestReg;
            WritebackDataOut = w_isLoad ? w_loadSlice : w_status;
        end
    end

    // Per-channel flags, FIFO head outputs and strobes
    always_comb begin
        w_full = '0; w_empty = '0; IOCmdACK = '0; IOResponseRequested = '0;
        IODestRegOut = '0; IODataOut = '0; IORespREQ = '0;
        w_push = '0; w_pop = '0; w_respAccept = '0; w_respFree = '0; w_outInc = '0;
        for (int c = 0; c < CHANNELCOUNT; c++) begin
            w_full[c]    = (r_count[c] == CNTW'(FIFODEPTH));
            w_empty[c]   = (r_count[c] == '0);
            IOCmdACK[c]  = !w_empty[c];
            {IOResponseRequested[c], IODestRegOut[c*4 +: 4], IODataOut[c*PW +: PW]} =
                r_fifoMem[c][r_rdPtr[c]];
            IORespREQ[c]    = !r_respValid[c];
            w_push[c]       = w_pushEn && (ChannelSelIn == CHBITS'(c));
            w_pop[c]        = IOCmdACK[c] && IOCmdREQ[c] && clk_en;
            w_respAccept[c] = IORespACK[c] && IORespREQ[c] && clk_en;
            w_respFree[c]   = w_respFire && (w_grantCh == CHBITS'(c));
            w_outInc[c]     = w_cmdFire && w_isAtomic && (ChannelSelIn == CHBITS'(c));
        end
    end

    // Command FIFOs: circular buffers with explicit occupancy count
    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            for (int c = 0; c < CHANNELCOUNT; c++) begin
                r_wrPtr[c] <= '0;
                r_rdPtr[c] <= '0;
                r_count[c] <= '0;
                for (int d = 0; d < FIFODEPTH; d++) r_fifoMem[c][d] <= '0;
            end
        end else if (clk_en) begin
            for (int c = 0; c < CHANNELCOUNT; c++) begin
                if (w_push[c]) begin
                    r_fifoMem[c][r_wrPtr[c]] <= w_pushEntry;
                    r_wrPtr[c]               <= r_wrPtr[c] + PTRW'(1);
                end
                if (w_pop[c]) r_rdPtr[c] <= r_rdPtr[c] + PTRW'(1);
                if (w_push[c] && !w_pop[c])      r_count[c] <= r_count[c] + CNTW'(1);
                else if (!w_push[c] && w_pop[c]) r_count[c] <= r_count[c] - CNTW'(1);
            end
        end
    end

    // Stage registers collect store slices until the last slice pushes
    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            for (int c = 0; c < CHANNELCOUNT; c++) r_stageReg[c] <= '0;
        end else if (clk_en && w_cmdFire && w_isStore) begin
            r_stageReg[ChannelSelIn] <= w_stageMerged;
        end
    end

    // Response capture, load buffers and outstanding-atomic tracking
    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            r_respValid <= '0;
            for (int c = 0; c < CHANNELCOUNT; c++) begin
                r_respData[c]    <= '0;
                r_respDest[c]    <= '0;
                r_loadBuf[c]     <= '0;
                r_outstanding[c] <= '0;
            end
        end else if (clk_en) begin
            for (int c = 0; c < CHANNELCOUNT; c++) begin
                if (w_respAccept[c] && (IORegResponseFlag[c] || IOMemResponseFlag[c]))
                    r_loadBuf[c] <= IODataIn[c*PW +: PW];
                if (w_respAccept[c] && IORegResponseFlag[c]) begin
                    r_respValid[c] <= 1'b1;
                    r_respDest[c]  <= IODestRegIn[c*4 +: 4];
                    r_respData[c]  <= IODataIn[c*PW +: PW];
                end else if (w_respFree[c]) begin
                    r_respValid[c] <= 1'b0;
                end
                if (w_outInc[c] && !(w_respFree[c] && r_outstanding[c] != '0))
                    r_outstanding[c] <= r_outstanding[c] + OUTW'(1);
                else if (!w_outInc[c] && w_respFree[c] && r_outstanding[c] != '0)
                    r_outstanding[c] <= r_outstanding[c] - OUTW'(1);
            end
        end
    end

    // Round-robin pointer moves past the channel just written back
    always_ff @(posedge sys_clk) begin
        if (sync_rst)        r_rrPtr <= '0;
        else if (w_respFire) r_rrPtr <= w_grantCh + CHBITS'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_command_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_command_controller
// Description : Directed self-checking bench for the command controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_command_controller;

    localparam int CH = 4;
    localparam int PW = 32;
    localparam logic [3:0] c_LOAD   = 4'b0000;
    localparam logic [3:0] c_STORE  = 4'b0100;
    localparam logic [3:0] c_ATOMIC = 4'b1000;
    localparam logic [3:0] c_STATUS = 4'b1100;

    logic            sys_clk = 1'b0;
    logic            sync_rst, clk_en;
    logic            CommandACK, CommandREQ;
    logic [3:0]      MinorOpcodeIn;
    logic [1:0]      ChannelSelIn;
    logic [15:0]     CommandAddressIn_Offest, CommandDataIn;
    logic [3:0]      CommandDestReg;
    logic            WritebackACK, WritebackREQ;
    logic [3:0]      WritebackDestReg;
    logic [15:0]     WritebackDataOut;
    logic [CH-1:0]   IOCmdACK, IOCmdREQ, IOResponseRequested;
    logic [CH*4-1:0] IODestRegOut, IODestRegIn;
    logic [CH*PW-1:0] IODataOut, IODataIn;
    logic [CH-1:0]   IORespACK, IORespREQ, IORegResponseFlag, IOMemResponseFlag;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    multi_channel_command_controller dut (
        .sys_clk(sys_clk), .sync_rst(sync_rst), .clk_en(clk_en),
        .CommandACK(CommandACK), .CommandREQ(CommandREQ), .MinorOpcodeIn(MinorOpcodeIn),
        .ChannelSelIn(ChannelSelIn), .CommandAddressIn_Offest(CommandAddressIn_Offest),
        .CommandDataIn(CommandDataIn), .CommandDestReg(CommandDestReg),
        .WritebackACK(WritebackACK), .WritebackREQ(WritebackREQ),
        .WritebackDestReg(WritebackDestReg), .WritebackDataOut(WritebackDataOut),
        .IOCmdACK(IOCmdACK), .IOCmdREQ(IOCmdREQ), .IOResponseRequested(IOResponseRequested),
        .IODestRegOut(IODestRegOut), .IODataOut(IODataOut),
        .IORespACK(IORespACK), .IORespREQ(IORespREQ), .IORegResponseFlag(IORegResponseFlag),
        .IOMemResponseFlag(IOMemResponseFlag), .IODestRegIn(IODestRegIn), .IODataIn(IODataIn)
    );

    task automatic idle();
        clk_en = 1'b1; CommandACK = 1'b0; MinorOpcodeIn = c_LOAD; ChannelSelIn = '0;
        CommandAddressIn_Offest = '0; CommandDataIn = '0; CommandDestReg = '0;
        WritebackREQ = 1'b1; IOCmdREQ = '0; IORespACK = '0; IORegResponseFlag = '0;
        IOMemResponseFlag = '0; IODestRegIn = '0; IODataIn = '0;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [1:0] ch, input logic [15:0] addr,
                       input logic [15:0] data, input logic [3:0] dest);
        CommandACK = 1'b1; MinorOpcodeIn = op; ChannelSelIn = ch;
        CommandAddressIn_Offest = addr; CommandDataIn = data; CommandDestReg = dest;
    endtask

    task automatic do_reset();
        @(negedge sys_clk); idle(); sync_rst = 1'b1;
        @(negedge sys_clk); sync_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk); idle(); sync_rst = 1'b1; clk_en = 1'b0;
        @(negedge sys_clk); sync_rst = 1'b0; clk_en = 1'b1; #1;
        total++; if (IOCmdACK !== 4'h0) begin bad++; $display("FAIL rst_iocmdack: got %h want 0", IOCmdACK); end
        total++; if (IORespREQ !== 4'hF) begin bad++; $display("FAIL rst_iorespreq: got %h want f", IORespREQ); end
        total++; if (WritebackACK !== 1'b0) begin bad++; $display("FAIL rst_wback_idle: got %b want 0", WritebackACK); end
        cmd(c_LOAD, 2'd0, 16'd0, 16'd0, 4'd1); #1;
        total++; if (WritebackACK !== 1'b1 || CommandREQ !== 1'b1 || WritebackDataOut !== 16'h0)
            begin bad++; $display("FAIL rst_load: got ack=%b req=%b data=%h want 1 1 0000", WritebackACK, CommandREQ, WritebackDataOut); end
        cmd(c_STATUS, 2'd2, 16'd0, 16'd0, 4'd1); #1;
        total++; if (WritebackDataOut !== 16'h0001) begin bad++; $display("FAIL rst_status: got %h want 0001", WritebackDataOut); end
        @(negedge sys_clk); idle();
    endtask

    task automatic test_store_assembly();
        do_reset();
        cmd(c_STORE, 2'd2, 16'd0, 16'hBEEF, 4'd3); #1;
        total++; if (CommandREQ !== 1'b1) begin bad++; $display("FAIL st_slice0_req: got %b want 1", CommandREQ); end
        @(negedge sys_clk); cmd(c_STORE, 2'd2, 16'd1, 16'hCAFE, 4'd3); #1;
        total++; if (IOCmdACK[2] !== 1'b0 || CommandREQ !== 1'b1) begin bad++; $display("FAIL st_slice1: got ack=%b req=%b want 0 1", IOCmdACK[2], CommandREQ); end
        @(negedge sys_clk); idle(); #1;
        total++; if (IOCmdACK[2] !== 1'b1 || IODataOut[64 +: 32] !== 32'hCAFEBEEF || IOResponseRequested[2] !== 1'b0 || IODestRegOut[8 +: 4] !== 4'd3)
            begin bad++; $display("FAIL st_head: got ack=%b data=%h rr=%b dest=%h want 1 cafebeef 0 3", IOCmdACK[2], IODataOut[64 +: 32], IOResponseRequested[2], IODestRegOut[8 +: 4]); end
        IOCmdREQ[2] = 1'b1;
        @(negedge sys_clk); IOCmdREQ = '0; #1;
        total++; if (IOCmdACK[2] !== 1'b0) begin bad++; $display("FAIL st_popped: got %b want 0", IOCmdACK[2]); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cmd(c_STORE, 2'd0, 16'd1, 16'h0011 + 16'(i), 4'(i + 1)); #1;
            total++; if (CommandREQ !== 1'b1) begin bad++; $display("FAIL ff_fill%0d: got %b want 1", i, CommandREQ); end
            @(negedge sys_clk);
        end
        cmd(c_STORE, 2'd0, 16'd1, 16'h0015, 4'd5); IOCmdREQ[0] = 1'b1; #1;
        total++; if (CommandREQ !== 1'b0) begin bad++; $display("FAIL ff_stall: got %b want 0", CommandREQ); end
        total++; if (IODataOut[31:0] !== 32'h0011_0000 || IODestRegOut[3:0] !== 4'd1)
            begin bad++; $display("FAIL ff_head1: got %h/%h want 00110000/1", IODataOut[31:0], IODestRegOut[3:0]); end
        @(negedge sys_clk); #1;
        total++; if (CommandREQ !== 1'b1) begin bad++; $display("FAIL ff_unstall: got %b want 1", CommandREQ); end
        total++; if (IODataOut[31:0] !== 32'h0012_0000) begin bad++; $display("FAIL ff_head2: got %h want 00120000", IODataOut[31:0]); end
        @(negedge sys_clk); CommandACK = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            #1; exp = {16'h0010 + 16'(k), 16'h0000};
            total++; if (IOCmdACK[0] !== 1'b1 || IODataOut[31:0] !== exp || IODestRegOut[3:0] !== 4'(k))
                begin bad++; $display("FAIL ff_head%0d: got ack=%b %h/%h want 1 %h/%h", k, IOCmdACK[0], IODataOut[31:0], IODestRegOut[3:0], exp, 4'(k)); end
            @(negedge sys_clk);
        end
        #1;
        total++; if (IOCmdACK[0] !== 1'b0) begin bad++; $display("FAIL ff_drained: got %b want 0", IOCmdACK[0]); end
        IOCmdREQ = '0;
    endtask

    task automatic test_atomic_limit();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd(c_ATOMIC, 2'd1, 16'd0, 16'd0, 4'(i + 1)); #1;
            total++; if (CommandREQ !== 1'b1) begin bad++; $display("FAIL at_issue%0d: got %b want 1", i, CommandREQ); end
            @(negedge sys_clk);
        end
        cmd(c_ATOMIC, 2'd1, 16'd0, 16'd0, 4'd4); #1;
        total++; if (CommandREQ !== 1'b0) begin bad++; $display("FAIL at_limit: got %b want 0", CommandREQ); end
        total++; if (IOResponseRequested[1] !== 1'b1 || IODestRegOut[7:4] !== 4'd1)
            begin bad++; $display("FAIL at_head: got rr=%b dest=%h want 1 1", IOResponseRequested[1], IODestRegOut[7:4]); end
        @(negedge sys_clk); cmd(c_STATUS, 2'd1, 16'd0, 16'd0, 4'd0); #1;
        total++; if (WritebackDataOut !== 16'h006C) begin bad++; $display("FAIL at_status3: got %h want 006c", WritebackDataOut); end
        @(negedge sys_clk); CommandACK = 1'b0;
        IORespACK[1] = 1'b1; IORegResponseFlag[1] = 1'b1; IODestRegIn[7:4] = 4'd5; IODataIn[63:32] = 32'h0000_1234; #1;
        total++; if (IORespREQ[1] !== 1'b1 || WritebackACK !== 1'b0) begin bad++; $display("FAIL at_resp_in: got req=%b wb=%b want 1 0", IORespREQ[1], WritebackACK); end
        @(negedge sys_clk); idle(); cmd(c_ATOMIC, 2'd1, 16'd0, 16'd0, 4'd4); #1;
        total++; if (WritebackACK !== 1'b1 || WritebackDestReg !== 4'd5 || WritebackDataOut !== 16'h1234 || CommandREQ !== 1'b0)
            begin bad++; $display("FAIL at_wb: got ack=%b dest=%h data=%h req=%b want 1 5 1234 0", WritebackACK, WritebackDestReg, WritebackDataOut, CommandREQ); end
        @(negedge sys_clk); cmd(c_STATUS, 2'd1, 16'd0, 16'd0, 4'd0); #1;
        total++; if (WritebackDataOut !== 16'h004C) begin bad++; $display("FAIL at_status2: got %h want 004c", WritebackDataOut); end
        @(negedge sys_clk); cmd(c_ATOMIC, 2'd1, 16'd0, 16'd0, 4'd4); #1;
        total++; if (CommandREQ !== 1'b1) begin bad++; $display("FAIL at_fourth: got %b want 1", CommandREQ); end
        @(negedge sys_clk); cmd(c_STATUS, 2'd1, 16'd0, 16'd0, 4'd0); #1;
        total++; if (WritebackDataOut !== 16'h0072) begin bad++; $display("FAIL at_status_full: got %h want 0072", WritebackDataOut); end
        @(negedge sys_clk); idle();
    endtask

    task automatic test_round_robin();
        logic [3:0]  expDest [3];
        logic [15:0] expData [3];
        expDest = '{4'd7, 4'd8, 4'd9};
        expData = '{16'h0100, 16'h0200, 16'h0300};
        do_reset();
        IORespACK = 4'b1011; IORegResponseFlag = 4'b1011;
        IODestRegIn = {4'h9, 4'h0, 4'h8, 4'h7};
        IODataIn = {32'h0000_0300, 32'h0, 32'h0000_0200, 32'h0000_0100}; #1;
        total++; if (IORespREQ !== 4'hF) begin bad++; $display("FAIL rr_accept: got %h want f", IORespREQ); end
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk); idle(); cmd(c_LOAD, 2'd0, 16'd0, 16'd0, 4'd2); #1;
            total++; if (WritebackACK !== 1'b1 || WritebackDestReg !== expDest[k] || WritebackDataOut !== expData[k] || CommandREQ !== 1'b0)
                begin bad++; $display("FAIL rr_grant%0d: got ack=%b dest=%h data=%h req=%b want 1 %h %h 0", k, WritebackACK, WritebackDestReg, WritebackDataOut, CommandREQ, expDest[k], expData[k]); end
        end
        @(negedge sys_clk); #1;
        total++; if (CommandREQ !== 1'b1 || WritebackACK !== 1'b1 || WritebackDestReg !== 4'd2 || WritebackDataOut !== 16'h0100)
            begin bad++; $display("FAIL rr_load_after: got req=%b ack=%b dest=%h data=%h want 1 1 2 0100", CommandREQ, WritebackACK, WritebackDestReg, WritebackDataOut); end
        @(negedge sys_clk); idle();
    endtask

    task automatic test_mem_response();
        do_reset();
        IORespACK[3] = 1'b1; IOMemResponseFlag[3] = 1'b1; IODataIn[127:96] = 32'hA5A5_5A5A;
        IORespACK[2] = 1'b1; IODataIn[95:64] = 32'hFFFF_FFFF; #1;
        total++; if (IORespREQ[3] !== 1'b1) begin bad++; $display("FAIL mr_req: got %b want 1", IORespREQ[3]); end
        @(negedge sys_clk); idle(); #1;
        total++; if (IORespREQ !== 4'hF || WritebackACK !== 1'b0) begin bad++; $display("FAIL mr_not_held: got req=%h wb=%b want f 0", IORespREQ, WritebackACK); end
        @(negedge sys_clk); cmd(c_LOAD, 2'd3, 16'd1, 16'd0, 4'd4); #1;
        total++; if (WritebackACK !== 1'b1 || WritebackDataOut !== 16'hA5A5 || WritebackDestReg !== 4'd4)
            begin bad++; $display("FAIL mr_load_hi: got ack=%b data=%h dest=%h want 1 a5a5 4", WritebackACK, WritebackDataOut, WritebackDestReg); end
        CommandAddressIn_Offest = 16'd0; #1;
        total++; if (WritebackDataOut !== 16'h5A5A) begin bad++; $display("FAIL mr_load_lo: got %h want 5a5a", WritebackDataOut); end
        @(negedge sys_clk); cmd(c_LOAD, 2'd2, 16'd0, 16'd0, 4'd4); #1;
        total++; if (WritebackDataOut !== 16'h0000) begin bad++; $display("FAIL mr_dropped: got %h want 0000", WritebackDataOut); end
        @(negedge sys_clk); cmd(c_STATUS, 2'd3, 16'd0, 16'd0, 4'd4); #1;
        total++; if (WritebackDataOut !== 16'h0001) begin bad++; $display("FAIL mr_status: got %h want 0001", WritebackDataOut); end
        @(negedge sys_clk); idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd(c_STORE, 2'd0, 16'd1, 16'h1111, 4'd1);
        @(negedge sys_clk); cmd(c_STORE, 2'd0, 16'd1, 16'h2222, 4'd2);
        @(negedge sys_clk); cmd(c_ATOMIC, 2'd1, 16'd0, 16'd0, 4'd6);
        @(negedge sys_clk); idle(); WritebackREQ = 1'b0;
        IORespACK[1] = 1'b1; IORegResponseFlag[1] = 1'b1; IODestRegIn[7:4] = 4'd6; IODataIn[63:32] = 32'h77;
        @(negedge sys_clk); idle(); WritebackREQ = 1'b0; #1;
        total++; if (WritebackACK !== 1'b1 || IOCmdACK !== 4'b0011)
            begin bad++; $display("FAIL rm_before: got wb=%b cmdack=%h want 1 3", WritebackACK, IOCmdACK); end
        @(negedge sys_clk); sync_rst = 1'b1; clk_en = 1'b0;
        @(negedge sys_clk); sync_rst = 1'b0; clk_en = 1'b1; WritebackREQ = 1'b1; #1;
        total++; if (IOCmdACK !== 4'h0 || WritebackACK !== 1'b0 || IORespREQ !== 4'hF)
            begin bad++; $display("FAIL rm_after: got cmdack=%h wb=%b respreq=%h want 0 0 f", IOCmdACK, WritebackACK, IORespREQ); end
        cmd(c_STATUS, 2'd1, 16'd0, 16'd0, 4'd0); #1;
        total++; if (WritebackDataOut !== 16'h0001) begin bad++; $display("FAIL rm_outstanding: got %h want 0001", WritebackDataOut); end
        @(negedge sys_clk); idle();
    endtask

    task automatic test_clk_en();
        do_reset();
        clk_en = 1'b0; cmd(c_STORE, 2'd2, 16'd1, 16'h4444, 4'd1);
        IORespACK[0] = 1'b1; IORegResponseFlag[0] = 1'b1;
        @(negedge sys_clk); idle(); #1;
        total++; if (IOCmdACK !== 4'h0 || IORespREQ !== 4'hF)
            begin bad++; $display("FAIL ce_hold: got cmdack=%h respreq=%h want 0 f", IOCmdACK, IORespREQ); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle(); sync_rst = 1'b1;
        test_reset();
        test_store_assembly();
        test_fifo_full();
        test_atomic_limit();
        test_round_robin();
        test_mem_response();
        test_reset_mid();
        test_clk_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
